// File: rtl/enc_pkg.sv
// Shared constants for the encoder activation path: PLAN sigmoid breakpoints and
// offsets in Q4.11, plus the sequencer state encoding.
package enc_pkg;

    localparam int BITSIZE = 16;
    localparam int FRAC    = 11;
    localparam int N       = 6;

    localparam int PLAN_FRAC    = 11;
    localparam int PLAN_BP_HI   = 'h2800;
    localparam int PLAN_BP_LO   = 'h1300;
    localparam int PLAN_OFS_HI  = 'h06C0;
    localparam int PLAN_OFS_MID = 'h0500;
    localparam int PLAN_OFS_LO  = 'h0400;
    localparam int PLAN_ONE     = 'h0800;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Constants are written in Q.11; rescale them when the datapath uses another FRAC.
    function automatic int plan_scale(input int c, input int frac);
        return (frac >= PLAN_FRAC) ? (c <<< (frac - PLAN_FRAC)) : (c >>> (PLAN_FRAC - frac));
    endfunction

endpackage

// File: rtl/plan_sigmoid.sv
// Combinational PLAN piecewise-linear sigmoid for one signed fixed-point element.
// Output always lies in [0, ONE].
module plan_sigmoid
    import enc_pkg::*;
#(
    parameter int BITSIZE = 16,
    parameter int FRAC    = 11
) (
    input  logic [BITSIZE-1:0] x,
    output logic [BITSIZE-1:0] y
);

    localparam logic [BITSIZE-1:0] BP_HI   = BITSIZE'(plan_scale(PLAN_BP_HI, FRAC));
    localparam logic [BITSIZE-1:0] BP_LO   = BITSIZE'(plan_scale(PLAN_BP_LO, FRAC));
    localparam logic [BITSIZE-1:0] OFS_HI  = BITSIZE'(plan_scale(PLAN_OFS_HI, FRAC));
    localparam logic [BITSIZE-1:0] OFS_MID = BITSIZE'(plan_scale(PLAN_OFS_MID, FRAC));
    localparam logic [BITSIZE-1:0] OFS_LO  = BITSIZE'(plan_scale(PLAN_OFS_LO, FRAC));
    localparam logic [BITSIZE-1:0] ONE     = BITSIZE'(plan_scale(PLAN_ONE, FRAC));
    localparam logic [BITSIZE-1:0] MOST_NEG = {1'b1, {(BITSIZE-1){1'b0}}};
    localparam logic [BITSIZE-1:0] MOST_POS = {1'b0, {(BITSIZE-1){1'b1}}};

    logic                neg;
    logic [BITSIZE-1:0]  a;
    logic [BITSIZE-1:0]  f;

    always_comb begin
        neg = x[BITSIZE-1];
        // Negating the most negative code would wrap, so clamp its magnitude.
        if (x == MOST_NEG) begin
            a = MOST_POS;
        end else if (neg) begin
            a = -x;
        end else begin
            a = x;
        end

        if (a >= BP_HI) begin
            f = ONE;
        end else if (a >= BP_LO) begin
            f = (a >> 5) + OFS_HI;
        end else if (a >= ONE) begin
            f = (a >> 3) + OFS_MID;
        end else begin
            f = (a >> 2) + OFS_LO;
        end

        y = neg ? (ONE - f) : f;
    end

endmodule

// File: rtl/sig_plan_seq.sv
// Sequential sigmoid stage: captures a packed vector, activates one element per cycle
// and holds the packed result until the downstream layer takes it.
module sig_plan_seq
    import enc_pkg::*;
#(
    parameter int BITSIZE = enc_pkg::BITSIZE,
    parameter int FRAC    = enc_pkg::FRAC,
    parameter int N       = enc_pkg::N
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BITSIZE*N-1:0] x_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BITSIZE*N-1:0] y_out,
    output logic                 busy
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    seq_state_e             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [BITSIZE*N-1:0]   x_q, x_d;
    logic [BITSIZE*N-1:0]   y_q, y_d;
    logic                   out_valid_q, out_valid_d;
    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d;

    logic [BITSIZE-1:0]     elem_x;
    logic [BITSIZE-1:0]     elem_y;

    assign elem_x = x_q[int'(idx_q)*BITSIZE +: BITSIZE];

    plan_sigmoid #(
        .BITSIZE (BITSIZE),
        .FRAC    (FRAC)
    ) u_plan_sigmoid (
        .x (elem_x),
        .y (elem_y)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_d         = x_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    x_d        = x_in;
                    idx_d      = '0;
                    state_d    = ST_RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_RUN: begin
                y_d[int'(idx_q)*BITSIZE +: BITSIZE] = elem_y;
                if (idx_q == IDX_LAST) begin
                    idx_d       = '0;
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                // in_ready is registered, so the next vector is taken one cycle after this handshake.
                if (out_ready && out_valid_q) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                idx_d       = '0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y_out     = y_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sig_plan_seq.sv
// Directed and randomized bench for sig_plan_seq against an arithmetic PLAN reference.
module tb_sig_plan_seq;

    localparam int B = 16;
    localparam int N = 6;
    localparam int W = B * N;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] x_in = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] y_out;
    logic         busy;

    int total = 0;
    int bad = 0;
    logic [W-1:0] prev_y = '0;

    sig_plan_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] plan_ref(input logic [15:0] xv);
        int x, a, f;
        x = int'($signed(xv));
        a = (x < 0) ? -x : x;
        if (a > 32767) a = 32767;
        if (a >= 10240)     f = 2048;
        else if (a >= 4864) f = a / 32 + 1728;
        else if (a >= 2048) f = a / 8 + 1280;
        else                f = a / 4 + 1024;
        return (x < 0) ? 16'(2048 - f) : 16'(f);
    endfunction

    function automatic logic [W-1:0] vec_ref(input logic [W-1:0] xv);
        logic [W-1:0] r;
        for (int k = 0; k < N; k++) r[B*k +: B] = plan_ref(xv[B*k +: B]);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_vec();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Emulates the upstream 6x10 MVM in Q4.11 with saturation to 16 bits.
    function automatic logic [W-1:0] enc_vec();
        logic [W-1:0] r;
        int u[10];
        for (int j = 0; j < 10; j++) u[j] = int'($urandom_range(0, 16383)) - 8192;
        for (int i = 0; i < N; i++) begin
            longint acc = 0;
            for (int j = 0; j < 10; j++) acc += longint'(int'($urandom_range(0, 4095)) - 2048) * u[j];
            acc = acc >>> 11;
            if (acc > 32767) acc = 32767;
            if (acc < -32768) acc = -32768;
            r[B*i +: B] = 16'(acc);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is 1 time unit past a rising edge; returns at the same phase with out_valid high.
    task automatic run_vec(input string tag, input logic [W-1:0] vec);
        logic [W-1:0] exp;
        int cyc;
        exp = vec_ref(vec);
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_in_ready"}, W'(in_ready), W'(1));
        in_valid = 1'b1;
        x_in     = vec;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x_in     = rand_vec();
        check({tag, "_busy"}, W'(busy), W'(1));
        for (int k = 0; k < N; k++) begin
            @(posedge clk); #1;
            check($sformatf("%s_el%0d", tag, k), W'(y_out[B*k +: B]), W'(exp[B*k +: B]));
            if (k < N - 1)
                check($sformatf("%s_hold%0d", tag, k + 1), W'(y_out[B*(k+1) +: B]), W'(prev_y[B*(k+1) +: B]));
            check($sformatf("%s_ov%0d", tag, k), W'(out_valid), W'(k == N - 1));
        end
        check({tag, "_vec"}, y_out, exp);
        prev_y = exp;
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_rel_ov"}, W'(out_valid), W'(0));
        check({tag, "_rel_rdy"}, W'(in_ready), W'(1));
        check({tag, "_rel_busy"}, W'(busy), W'(0));
    endtask

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] q_exp[$];
        int ins, outs, last_out;

        #12;
        check("rst_ov", W'(out_valid), W'(0));
        check("rst_rdy", W'(in_ready), W'(1));
        check("rst_busy", W'(busy), W'(0));
        check("rst_y", y_out, '0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        run_vec("zero", '0);
        check("zero_const", y_out, {N{16'h0400}});
        release_out("zero");

        run_vec("mixed", {16'h3000, 16'h1800, 16'h1000, 16'h0400, 16'hF800, 16'h0800});
        check("mixed_const", y_out, {16'h0800, 16'h0780, 16'h0700, 16'h0500, 16'h0200, 16'h0600});
        release_out("mixed");

        run_vec("sat", {16'h07FF, 16'h1300, 16'hD800, 16'h2800, 16'h7FFF, 16'h8000});
        check("sat_const", y_out, {16'h05FF, 16'h0758, 16'h0000, 16'h0800, 16'h0800, 16'h0000});

        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            x_in     = rand_vec();
            @(posedge clk); #1;
            check($sformatf("bp_ov%0d", c), W'(out_valid), W'(1));
            check($sformatf("bp_rdy%0d", c), W'(in_ready), W'(0));
            check($sformatf("bp_y%0d", c), y_out, prev_y);
        end
        in_valid = 1'b0;
        release_out("bp");

        v = rand_vec();
        in_valid = 1'b1;
        x_in     = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("mid_el2", W'(y_out[B*2 +: B]), W'(plan_ref(v[B*2 +: B])));
        reset = 1'b0;
        #1;
        check("mrst_y", y_out, '0);
        check("mrst_ov", W'(out_valid), W'(0));
        check("mrst_rdy", W'(in_ready), W'(1));
        check("mrst_busy", W'(busy), W'(0));
        prev_y = '0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        run_vec("post_rst", rand_vec());
        release_out("post_rst");

        ins = 0;
        outs = 0;
        last_out = -1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x_in      = rand_vec();
        for (int c = 0; c < 200 && outs < 5; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                q_exp.push_back(vec_ref(x_in));
                ins++;
            end
            if (out_valid) begin
                if (q_exp.size() == 0) begin
                    check("b2b_spurious", y_out, ~y_out);
                end else begin
                    prev_y = q_exp.pop_front();
                    check($sformatf("b2b_y%0d", outs), y_out, prev_y);
                end
                if (last_out >= 0) check($sformatf("b2b_gap%0d", outs), W'(c - last_out), W'(N + 2));
                last_out = c;
                outs++;
            end
            @(posedge clk); #1;
            x_in     = rand_vec();
            in_valid = (ins < 5);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("b2b_outs", W'(outs), W'(5));
        check("b2b_ins", W'(ins), W'(5));
        check("b2b_left", W'(q_exp.size()), W'(0));

        for (int t = 0; t < 8; t++) begin
            run_vec($sformatf("enc%0d", t), enc_vec());
            release_out($sformatf("enc%0d", t));
        end
        for (int t = 0; t < 4; t++) begin
            run_vec($sformatf("rnd%0d", t), rand_vec());
            release_out($sformatf("rnd%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
